lsu_sram_master: RTL

- Load/store initiator that drives the simulation SRAM port (addr/wdata/wmask/ena/wen → rdata) on behalf of the core's memory stage.
- Accepts one byte, half or word access at a time over a valid/ready request channel, aligns store data and byte masks, and issues a single SRAM cycle.
- Captures and sign- or zero-extends the load data, then returns a completion on a valid/ready response channel.
- Misaligned and illegal-size requests complete with an error and no SRAM access.

---
 rtl/lsu_sram_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_sram_master.sv
// lsu_sram_master
// Load/store initiator sitting between the core's memory stage and the
// simulation SRAM port. It takes one byte/half/word access per request
// handshake, drives a single SRAM cycle with lane-aligned data and byte mask,
// extends the returned load data, and hands back a completion on the
// response channel. Misaligned or illegal-size requests skip the SRAM and
// complete with an error.
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_addr            : byte address (ADDR_W bits)
//   req_wen             : 1 = store, 0 = load
//   req_size            : 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned        : zero-extend loads when 1, sign-extend when 0
//   req_wdata           : right-justified store data
//   resp_valid/ready    : completion handshake
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_err            : misaligned or illegal-size request
//   mem_addr            : word-aligned SRAM address
//   mem_wdata           : lane-shifted store data
//   mem_wmask           : byte mask, upper nibble always 0
//   mem_ena, mem_wen    : SRAM access / write enables
//   mem_rdata           : SRAM read data, valid the cycle after mem_ena

module lsu_sram_master #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  output logic              mem_ena,
  output logic              mem_wen,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0] addr_ext;
  logic [1:0]  off;
  logic [4:0]  shamt;
  logic        req_bad;
  logic [3:0]  lane_mask;
  logic [31:0] lane;
  logic [31:0] load_ext;

  assign addr_ext = 32'(addr_q);
  assign off      = addr_q[1:0];
  assign shamt    = {off, 3'b000};

  // Decide at acceptance whether the request may touch the SRAM at all.
  // With alignment checking disabled only the illegal size is rejected.
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'd3) begin
      req_bad = 1'b1;
    end else if (CHECK_ALIGN) begin
      if (req_size == 2'd1 && req_addr[0])
        req_bad = 1'b1;
      else if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
        req_bad = 1'b1;
    end
  end

  // Byte-lane mask for stores; the half mask is computed in 4 bits so an
  // unchecked half at offset 3 simply loses the lane past the word.
  always_comb begin
    lane_mask = 4'h0;
    unique case (size_q)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    lane     = mem_rdata >> shamt;
    load_ext = lane;
    unique case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'h0, lane[7:0]}
                                     : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'h0, lane[15:0]}
                                     : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Request fields are captured only at the acceptance edge; the response
  // registers are filled either at acceptance (error path) or in CAPTURE.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q     <= req_addr;
        wen_q      <= req_wen;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
        rdata_q    <= 32'h0;
        err_q      <= req_bad;
      end else if (state == CAPTURE) begin
        rdata_q <= wen_q ? 32'h0 : load_ext;
        err_q   <= 1'b0;
      end
    end
  end

  // Next state and port decode; every output is a function of the state
  // register and the latched request, so nothing is combinational from inputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_ena    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_wmask  = 8'h0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_ena    = 1'b1;
        mem_wen    = wen_q;
        mem_addr   = {addr_ext[31:2], 2'b00};
        mem_wdata  = wdata_q << shamt;
        mem_wmask  = wen_q ? {4'h0, lane_mask} : 8'h0;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
